// File: rtl/alu_flag_stage.sv
// alu_flag_stage: registered ARM data-processing ALU stage with NZCV flag register.
// Takes operand 2 and the shifter carry from the barrel shifter and combines them
// with Rn. The result goes into a one-entry valid/ready output register with
// 1-cycle latency. The flags C bit is fed back to the shifter as Carry_flag.
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   in_valid / in_ready                upstream handshake (in_ready is combinational)
//   ALU_OP, S_bit                      opcode, flag-update enable
//   Rn_Data, Shift_Out, Shift_Carry_Out operands A, B and shifter carry
//   out_valid / out_ready              downstream handshake
//   ALU_Out, Result_Write              registered result and writeback enable
//   NZCV, Carry_flag                   flag register and its C bit
module alu_flag_stage #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        ALU_OP,
  input  logic              S_bit,
  input  logic [DATA_W-1:0] Rn_Data,
  input  logic [DATA_W-1:0] Shift_Out,
  input  logic              Shift_Carry_Out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ALU_Out,
  output logic              Result_Write,
  output logic [3:0]        NZCV,
  output logic              Carry_flag
);

  localparam int unsigned SUM_W = DATA_W + 1;
  localparam int unsigned MSB   = DATA_W - 1;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_EOR = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_ADC = 4'h5;
  localparam logic [3:0] OP_SBC = 4'h6;
  localparam logic [3:0] OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8;
  localparam logic [3:0] OP_TEQ = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_BIC = 4'hE;
  localparam logic [3:0] OP_MVN = 4'hF;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] alu_out_q, alu_out_d;
  logic              result_write_q, result_write_d;
  logic [3:0]        nzcv_q, nzcv_d;

  logic              accept;
  logic              is_arith;
  logic [DATA_W-1:0] add_x, add_y;
  logic              add_cin;
  logic [SUM_W-1:0]  sum;
  logic [DATA_W-1:0] res;
  logic              flag_n, flag_z, flag_c, flag_v;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Adder operand selection; reverse-subtracts swap A/B, subtracts invert the subtrahend
  always_comb begin
    is_arith = 1'b0;
    add_x    = '0;
    add_y    = '0;
    add_cin  = 1'b0;
    case (ALU_OP)
      OP_ADD, OP_CMN: begin is_arith = 1'b1; add_x = Rn_Data;   add_y = Shift_Out;  add_cin = 1'b0;      end
      OP_ADC:         begin is_arith = 1'b1; add_x = Rn_Data;   add_y = Shift_Out;  add_cin = nzcv_q[1]; end
      OP_SUB, OP_CMP: begin is_arith = 1'b1; add_x = Rn_Data;   add_y = ~Shift_Out; add_cin = 1'b1;      end
      OP_SBC:         begin is_arith = 1'b1; add_x = Rn_Data;   add_y = ~Shift_Out; add_cin = nzcv_q[1]; end
      OP_RSB:         begin is_arith = 1'b1; add_x = Shift_Out; add_y = ~Rn_Data;   add_cin = 1'b1;      end
      OP_RSC:         begin is_arith = 1'b1; add_x = Shift_Out; add_y = ~Rn_Data;   add_cin = nzcv_q[1]; end
      default: ;
    endcase
    sum = {1'b0, add_x} + {1'b0, add_y} + SUM_W'(add_cin);
  end

  // Result mux and flag computation
  always_comb begin
    res = sum[MSB:0];
    case (ALU_OP)
      OP_AND, OP_TST: res = Rn_Data & Shift_Out;
      OP_EOR, OP_TEQ: res = Rn_Data ^ Shift_Out;
      OP_ORR:         res = Rn_Data | Shift_Out;
      OP_MOV:         res = Shift_Out;
      OP_BIC:         res = Rn_Data & ~Shift_Out;
      OP_MVN:         res = ~Shift_Out;
      default: ;
    endcase
    flag_n = res[MSB];
    flag_z = (res == '0);
    // Logical ops take C from the shifter and leave V alone
    flag_c = is_arith ? sum[DATA_W] : Shift_Carry_Out;
    flag_v = is_arith ? ((add_x[MSB] == add_y[MSB]) && (res[MSB] != add_x[MSB])) : nzcv_q[0];
  end

  // Next-state for the output register and flags
  always_comb begin
    out_valid_d    = out_valid_q;
    alu_out_d      = alu_out_q;
    result_write_d = result_write_q;
    nzcv_d         = nzcv_q;
    if (accept) begin
      out_valid_d    = 1'b1;
      alu_out_d      = res;
      // TST/TEQ/CMP/CMN occupy opcodes 8..B
      result_write_d = (ALU_OP[3:2] != 2'b10);
      if (S_bit) nzcv_d = {flag_n, flag_z, flag_c, flag_v};
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q    <= 1'b0;
      alu_out_q      <= '0;
      result_write_q <= 1'b0;
      nzcv_q         <= 4'b0000;
    end else begin
      out_valid_q    <= out_valid_d;
      alu_out_q      <= alu_out_d;
      result_write_q <= result_write_d;
      nzcv_q         <= nzcv_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign ALU_Out      = alu_out_q;
  assign Result_Write = result_write_q;
  assign NZCV         = nzcv_q;
  assign Carry_flag   = nzcv_q[1];

endmodule

// File: tb/tb_alu_flag_stage.sv
// tb_alu_flag_stage: directed self-checking bench for alu_flag_stage.
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.
module tb_alu_flag_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ALU_OP;
  logic        S_bit;
  logic [31:0] Rn_Data;
  logic [31:0] Shift_Out;
  logic        Shift_Carry_Out;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALU_Out;
  logic        Result_Write;
  logic [3:0]  NZCV;
  logic        Carry_flag;

  int errors = 0;
  int checks = 0;

  alu_flag_stage #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .ALU_OP(ALU_OP), .S_bit(S_bit),
    .Rn_Data(Rn_Data), .Shift_Out(Shift_Out), .Shift_Carry_Out(Shift_Carry_Out),
    .out_valid(out_valid), .out_ready(out_ready),
    .ALU_Out(ALU_Out), .Result_Write(Result_Write),
    .NZCV(NZCV), .Carry_flag(Carry_flag)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one op for one cycle (caller guarantees in_ready=1)
  task automatic issue(input logic [3:0] op, input logic s, input logic [31:0] a,
                       input logic [31:0] b, input logic sc);
    ALU_OP = op; S_bit = s; Rn_Data = a; Shift_Out = b; Shift_Carry_Out = sc;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    ALU_OP = 4'h4; S_bit = 1'b1; Rn_Data = 32'h1234; Shift_Out = 32'h1; Shift_Carry_Out = 1'b1;
    step(); step();
    checks++;
    if ({out_valid, ALU_Out, Result_Write, NZCV, Carry_flag, in_ready} !== {1'b0, 32'h0, 1'b0, 4'b0000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset: got v=%b out=%h rw=%b nzcv=%b cf=%b rdy=%b, want v=0 out=0 rw=0 nzcv=0000 cf=0 rdy=1",
               out_valid, ALU_Out, Result_Write, NZCV, Carry_flag, in_ready);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_add_sub_cmp();
    issue(4'h4, 1'b1, 32'h7FFFFFFF, 32'h00000001, 1'b0);
    checks++;
    if ({out_valid, ALU_Out, Result_Write, NZCV} !== {1'b1, 32'h80000000, 1'b1, 4'b1001}) begin
      errors++;
      $display("FAIL add_ovf: got v=%b out=%h rw=%b nzcv=%b, want v=1 out=80000000 rw=1 nzcv=1001",
               out_valid, ALU_Out, Result_Write, NZCV);
    end
    issue(4'h2, 1'b1, 32'h5, 32'h5, 1'b0);
    checks++;
    if ({ALU_Out, Result_Write, NZCV} !== {32'h0, 1'b1, 4'b0110}) begin
      errors++;
      $display("FAIL sub_zero: got out=%h rw=%b nzcv=%b, want out=0 rw=1 nzcv=0110", ALU_Out, Result_Write, NZCV);
    end
    issue(4'hA, 1'b1, 32'h3, 32'h5, 1'b0);
    checks++;
    if ({ALU_Out, Result_Write, NZCV, Carry_flag} !== {32'hFFFFFFFE, 1'b0, 4'b1000, 1'b0}) begin
      errors++;
      $display("FAIL cmp_borrow: got out=%h rw=%b nzcv=%b cf=%b, want out=fffffffe rw=0 nzcv=1000 cf=0",
               ALU_Out, Result_Write, NZCV, Carry_flag);
    end
  endtask

  task automatic test_logical_keeps_v();
    // Build NZCV=0001: ADD overflow sets V, then ORR with S clears N/Z/C only
    issue(4'h4, 1'b1, 32'h7FFFFFFF, 32'h1, 1'b0);
    issue(4'hC, 1'b1, 32'h1, 32'h0, 1'b0);
    checks++;
    if ({ALU_Out, NZCV} !== {32'h1, 4'b0001}) begin
      errors++;
      $display("FAIL orr_preset: got out=%h nzcv=%b, want out=00000001 nzcv=0001", ALU_Out, NZCV);
    end
    issue(4'hD, 1'b1, 32'h0, 32'hF0000000, 1'b1);
    checks++;
    if ({ALU_Out, Result_Write, NZCV, Carry_flag} !== {32'hF0000000, 1'b1, 4'b1011, 1'b1}) begin
      errors++;
      $display("FAIL mov_keep_v: got out=%h rw=%b nzcv=%b cf=%b, want out=f0000000 rw=1 nzcv=1011 cf=1",
               ALU_Out, Result_Write, NZCV, Carry_flag);
    end
  endtask

  task automatic test_adc_carry();
    // Carry_flag=1 from the preceding MOV, consumed back-to-back
    issue(4'h5, 1'b1, 32'hFFFFFFFF, 32'h0, 1'b0);
    checks++;
    if ({ALU_Out, NZCV} !== {32'h0, 4'b0110}) begin
      errors++;
      $display("FAIL adc_cin1: got out=%h nzcv=%b, want out=0 nzcv=0110", ALU_Out, NZCV);
    end
    issue(4'hA, 1'b1, 32'h3, 32'h5, 1'b0);
    issue(4'h5, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b0);
    checks++;
    if ({ALU_Out, NZCV} !== {32'hFFFFFFFF, 4'b1000}) begin
      errors++;
      $display("FAIL adc_nos: got out=%h nzcv=%b, want out=ffffffff nzcv=1000", ALU_Out, NZCV);
    end
  endtask

  task automatic test_other_ops();
    // C=0 here, so SBC adds no extra 1
    issue(4'h6, 1'b1, 32'h10, 32'h3, 1'b0);
    checks++;
    if ({ALU_Out, NZCV} !== {32'hC, 4'b0010}) begin
      errors++;
      $display("FAIL sbc_cin0: got out=%h nzcv=%b, want out=0000000c nzcv=0010", ALU_Out, NZCV);
    end
    issue(4'h7, 1'b1, 32'h5, 32'h3, 1'b0);
    checks++;
    if ({ALU_Out, NZCV} !== {32'hFFFFFFFE, 4'b1000}) begin
      errors++;
      $display("FAIL rsc_cin1: got out=%h nzcv=%b, want out=fffffffe nzcv=1000", ALU_Out, NZCV);
    end
    issue(4'h3, 1'b1, 32'h1, 32'h3, 1'b0);
    checks++;
    if ({ALU_Out, NZCV} !== {32'h2, 4'b0010}) begin
      errors++;
      $display("FAIL rsb: got out=%h nzcv=%b, want out=00000002 nzcv=0010", ALU_Out, NZCV);
    end
    issue(4'hE, 1'b1, 32'hFF, 32'h0F, 1'b0);
    checks++;
    if ({ALU_Out, NZCV} !== {32'hF0, 4'b0000}) begin
      errors++;
      $display("FAIL bic: got out=%h nzcv=%b, want out=000000f0 nzcv=0000", ALU_Out, NZCV);
    end
    issue(4'hF, 1'b1, 32'h0, 32'h0, 1'b1);
    checks++;
    if ({ALU_Out, NZCV} !== {32'hFFFFFFFF, 4'b1010}) begin
      errors++;
      $display("FAIL mvn: got out=%h nzcv=%b, want out=ffffffff nzcv=1010", ALU_Out, NZCV);
    end
    issue(4'h1, 1'b1, 32'hAAAA, 32'hAAAA, 1'b0);
    checks++;
    if ({ALU_Out, Result_Write, NZCV} !== {32'h0, 1'b1, 4'b0100}) begin
      errors++;
      $display("FAIL eor: got out=%h rw=%b nzcv=%b, want out=0 rw=1 nzcv=0100", ALU_Out, Result_Write, NZCV);
    end
    issue(4'h8, 1'b1, 32'h1, 32'h2, 1'b1);
    checks++;
    if ({ALU_Out, Result_Write, NZCV} !== {32'h0, 1'b0, 4'b0110}) begin
      errors++;
      $display("FAIL tst: got out=%h rw=%b nzcv=%b, want out=0 rw=0 nzcv=0110", ALU_Out, Result_Write, NZCV);
    end
    issue(4'hB, 1'b1, 32'h80000000, 32'h80000000, 1'b0);
    checks++;
    if ({ALU_Out, Result_Write, NZCV} !== {32'h0, 1'b0, 4'b0111}) begin
      errors++;
      $display("FAIL cmn_ovf: got out=%h rw=%b nzcv=%b, want out=0 rw=0 nzcv=0111", ALU_Out, Result_Write, NZCV);
    end
  endtask

  task automatic test_back_to_back_stall();
    issue(4'h4, 1'b1, 32'h1, 32'h2, 1'b0);
    // Stall with a flag-setting op pending
    out_ready = 1'b0;
    ALU_OP = 4'h2; S_bit = 1'b1; Rn_Data = 32'h1; Shift_Out = 32'h2; Shift_Carry_Out = 1'b0;
    in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_rdy: got in_ready=%b, want 0", in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({out_valid, in_ready, ALU_Out, NZCV} !== {1'b1, 1'b0, 32'h3, 4'b0000}) begin
        errors++;
        $display("FAIL stall_hold%0d: got v=%b rdy=%b out=%h nzcv=%b, want v=1 rdy=0 out=00000003 nzcv=0000",
                 i, out_valid, in_ready, ALU_Out, NZCV);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL drain_rdy: got in_ready=%b, want 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, ALU_Out, NZCV} !== {1'b1, 32'hFFFFFFFF, 4'b1000}) begin
      errors++;
      $display("FAIL drain_accept: got v=%b out=%h nzcv=%b, want v=1 out=ffffffff nzcv=1000",
               out_valid, ALU_Out, NZCV);
    end
    step();
    checks++;
    if ({out_valid, ALU_Out, NZCV} !== {1'b0, 32'hFFFFFFFF, 4'b1000}) begin
      errors++;
      $display("FAIL drain_only: got v=%b out=%h nzcv=%b, want v=0 out=ffffffff nzcv=1000",
               out_valid, ALU_Out, NZCV);
    end
  endtask

  task automatic test_reset_in_stall();
    issue(4'h2, 1'b1, 32'h5, 32'h5, 1'b0);
    out_ready = 1'b0;
    ALU_OP = 4'h4; S_bit = 1'b1; Rn_Data = 32'h7FFFFFFF; Shift_Out = 32'h1;
    in_valid = 1'b1;
    step();
    checks++;
    if ({out_valid, Carry_flag, NZCV} !== {1'b1, 1'b1, 4'b0110}) begin
      errors++;
      $display("FAIL pre_reset: got v=%b cf=%b nzcv=%b, want v=1 cf=1 nzcv=0110", out_valid, Carry_flag, NZCV);
    end
    rst_n = 1'b0;
    step();
    checks++;
    if ({out_valid, ALU_Out, NZCV, Carry_flag, in_ready} !== {1'b0, 32'h0, 4'b0000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_stall: got v=%b out=%h nzcv=%b cf=%b rdy=%b, want v=0 out=0 nzcv=0000 cf=0 rdy=1",
               out_valid, ALU_Out, NZCV, Carry_flag, in_ready);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_add_sub_cmp();
    test_logical_keeps_v();
    test_adc_carry();
    test_other_ops();
    test_back_to_back_stall();
    test_reset_in_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
